// File: rtl/wb_sdr_master_pkg.sv
// rtl/wb_sdr_master_pkg.sv - shared types and constants for the Wishbone SDRAM traffic master
package wb_sdr_master_pkg;

    typedef enum logic [1:0] {
        INIT_WAIT = 2'd0,
        IDLE      = 2'd1,
        BUS       = 2'd2,
        FIN       = 2'd3
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_ack_timeout.sv
// rtl/wb_ack_timeout.sv - per-beat acknowledge watchdog counter
module wb_ack_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // expired fires in the cycle whose closing edge would bring the count to TIMEOUT,
    // so the master drops STB after exactly TIMEOUT unacknowledged cycles
    assign expired = (TIMEOUT != 0) && run && (count == LAST);

    // count consecutive unacknowledged strobe cycles; clear wins over run
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_sdr_master.sv
// rtl/wb_sdr_master.sv - Wishbone classic/incrementing-burst master for the SDRAM controller port
module wb_sdr_master #(
    parameter int AW      = 26,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024,
    parameter int LENW    = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sdr_init_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [DW/8-1:0]   cmd_sel,
    input  logic [LENW-1:0]   cmd_len,
    input  logic [DW-1:0]     wdata_i,
    output logic              wdata_rd,
    output logic [DW-1:0]     rdata_o,
    output logic              rdata_vld,
    output logic              done,
    output logic              err,
    output logic              spurious_ack,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i
);

    import wb_sdr_master_pkg::*;

    localparam logic [AW-1:0] ADR_STEP = AW'(DW / 8);

    state_t          state;
    logic [LENW-1:0] len_r;
    logic [LENW-1:0] beat_cnt;
    logic [LENW-1:0] next_beat;
    logic            init_lost;
    logic            accept;
    logic            ack_beat;
    logic            last_beat;
    logic            expired;

    assign cmd_ready = !wb_rst_i && (state == IDLE) && sdr_init_done;
    assign accept    = cmd_ready && cmd_valid;
    assign ack_beat  = (state == BUS) && wb_ack_i;
    assign last_beat = (beat_cnt == len_r);
    assign next_beat = beat_cnt + 1'b1;

    // FWFT pull: first word on accept, later words on each non-final write ACK
    assign wdata_rd = !wb_rst_i &&
                      ((accept && cmd_we) || (ack_beat && wb_we_o && !last_beat));

    // in BUS the strobe is always high, so leaving BUS is the only way STB falls
    wb_ack_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     ((state != BUS) || wb_ack_i),
        .run     (wb_stb_o && !wb_ack_i),
        .expired (expired)
    );

    // transaction sequencer with all bus and status outputs registered
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= INIT_WAIT;
            len_r        <= '0;
            beat_cnt     <= '0;
            init_lost    <= 1'b0;
            rdata_o      <= '0;
            rdata_vld    <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            spurious_ack <= 1'b0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '0;
            wb_cti_o     <= CTI_CLASSIC;
        end else begin
            rdata_vld <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            if (wb_ack_i && !wb_stb_o) begin
                spurious_ack <= 1'b1;
            end
            case (state)
                INIT_WAIT: begin
                    if (sdr_init_done) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_we_o   <= cmd_we;
                        wb_adr_o  <= cmd_addr;
                        wb_sel_o  <= cmd_sel;
                        wb_cti_o  <= (cmd_len == '0) ? CTI_CLASSIC : CTI_INCR;
                        if (cmd_we) begin
                            wb_dat_o <= wdata_i;
                        end
                        len_r     <= cmd_len;
                        beat_cnt  <= '0;
                        init_lost <= 1'b0;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    if (!sdr_init_done) begin
                        init_lost <= 1'b1;
                    end
                    if (wb_ack_i) begin
                        if (!wb_we_o) begin
                            rdata_o   <= wb_dat_i;
                            rdata_vld <= 1'b1;
                        end
                        wb_adr_o <= wb_adr_o + ADR_STEP;
                        beat_cnt <= next_beat;
                        if (last_beat) begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            wb_we_o  <= 1'b0;
                            wb_cti_o <= CTI_CLASSIC;
                            done     <= 1'b1;
                            state    <= FIN;
                        end else begin
                            if (wb_we_o) begin
                                wb_dat_o <= wdata_i;
                            end
                            wb_cti_o <= (next_beat == len_r) ? CTI_EOB : CTI_INCR;
                        end
                    end else if (expired) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_cti_o <= CTI_CLASSIC;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        state    <= FIN;
                    end
                end
                FIN: begin
                    state <= (init_lost || !sdr_init_done) ? INIT_WAIT : IDLE;
                end
                default: begin
                    state <= INIT_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sdr_master.sv
// tb/tb_wb_sdr_master.sv - self-checking bench for wb_sdr_master
module tb_wb_sdr_master;

    localparam int AW   = 26;
    localparam int DW   = 32;
    localparam int TO   = 16;
    localparam int LENW = 4;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i = 1'b1;
    logic            sdr_init_done = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_we = 1'b0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [3:0]      cmd_sel = '0;
    logic [LENW-1:0] cmd_len = '0;
    logic [DW-1:0]   wdata_i = '0;
    logic            wdata_rd;
    logic [DW-1:0]   rdata_o;
    logic            rdata_vld;
    logic            done;
    logic            err;
    logic            spurious_ack;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [3:0]      wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic            wb_ack_i = 1'b0;
    logic [DW-1:0]   wb_dat_i = '0;

    wb_sdr_master #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO),
        .LENW    (LENW)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .sdr_init_done (sdr_init_done),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_we        (cmd_we),
        .cmd_addr      (cmd_addr),
        .cmd_sel       (cmd_sel),
        .cmd_len       (cmd_len),
        .wdata_i       (wdata_i),
        .wdata_rd      (wdata_rd),
        .rdata_o       (rdata_o),
        .rdata_vld     (rdata_vld),
        .done          (done),
        .err           (err),
        .spurious_ack  (spurious_ack),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_we_o       (wb_we_o),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_o      (wb_dat_o),
        .wb_sel_o      (wb_sel_o),
        .wb_cti_o      (wb_cti_o),
        .wb_ack_i      (wb_ack_i),
        .wb_dat_i      (wb_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic            we;
        logic [AW-1:0]   addr;
        logic [3:0]      sel;
        logic [LENW-1:0] len;
        int              delay;
        logic [DW-1:0]   seed;
        logic            exp_err;
        int              exp_beats;
        int              exp_rd;
        int              exp_wr;
    } txn_t;

    txn_t          tbl[7];
    logic [DW-1:0] rd_sb[$];
    logic [DW-1:0] wr_sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    function automatic logic [DW-1:0] rpat(input logic [AW-1:0] a);
        return {a[23:0], 8'h5A} ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_sel_o, rdata_vld,
                                  done, err, spurious_ack, cmd_ready, wdata_rd}), 64'd0);
        check({tag, "_adr"}, 64'(wb_adr_o), 64'd0);
        check({tag, "_dat"}, 64'(wb_dat_o), 64'd0);
        check({tag, "_rdata"}, 64'(rdata_o), 64'd0);
    endtask

    task automatic run_txn(input int n);
        txn_t          t = tbl[n];
        logic [AW-1:0] exp_adr = t.addr;
        logic [2:0]    exp_cti;
        int            cycles = 0, acc_cyc = -1, stb_first = -1, acks = 0, rds = 0, wrs = 0;
        int            stb_cnt = 0, viol = 0, wait_cnt = 0, widx = 0;
        bit            got_done = 0, got_err = 0, acc_now, popped, bus_at_done = 1;
        string         p = $sformatf("t%0d", n);
        cmd_valid = 1'b1;
        cmd_we    = t.we;
        cmd_addr  = t.addr;
        cmd_sel   = t.sel;
        cmd_len   = t.len;
        wdata_i   = t.seed;
        wb_ack_i  = 1'b0;
        rd_sb.delete();
        wr_sb.delete();
        while (!got_done && cycles < 300) begin
            #1;
            acc_now = cmd_valid && cmd_ready;
            if (acc_now) acc_cyc = cycles;
            if (wb_stb_o) stb_cnt++;
            if (wb_stb_o && !wb_cyc_o) viol++;
            if (wb_ack_i && wb_stb_o) begin
                exp_cti = (t.len == '0) ? 3'b000 : ((acks == int'(t.len)) ? 3'b111 : 3'b010);
                check({p, "_adr"}, 64'(wb_adr_o), 64'(exp_adr));
                check({p, "_ctl"}, 64'({wb_we_o, wb_sel_o, wb_cti_o}), 64'({t.we, t.sel, exp_cti}));
                if (t.we) begin
                    if (wr_sb.size() == 0) viol++;
                    else check({p, "_wdat"}, 64'(wb_dat_o), 64'(wr_sb.pop_front()));
                end else begin
                    rd_sb.push_back(rpat(exp_adr));
                end
                exp_adr = exp_adr + 26'd4;
                acks++;
            end
            popped = wdata_rd;
            if (wdata_rd) begin
                if (!t.we) viol++;
                wr_sb.push_back(wdata_i);
                wrs++;
            end
            @(posedge wb_clk_i);
            cycles++;
            #1;
            if (acc_now) cmd_valid = 1'b0;
            if (popped) begin
                widx++;
                wdata_i = t.seed + 32'(widx) * 32'h0101_0101;
            end
            if (wb_stb_o && stb_first < 0) stb_first = cycles;
            if (rdata_vld) begin
                rds++;
                if (t.we || rd_sb.size() == 0) viol++;
                else check({p, "_rdata"}, 64'(rdata_o), 64'(rd_sb.pop_front()));
            end
            if (done) begin
                got_done    = 1;
                got_err     = err;
                bus_at_done = wb_cyc_o | wb_stb_o;
            end
            wb_ack_i = 1'b0;
            wb_dat_i = rpat(wb_adr_o);
            if (wb_stb_o) begin
                if (wait_cnt >= t.delay) begin
                    wb_ack_i = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
        check({p, "_done"}, 64'(got_done), 64'd1);
        check({p, "_err"}, 64'(got_err), 64'(t.exp_err));
        check({p, "_beats"}, 64'(acks), 64'(t.exp_beats));
        check({p, "_rdvld_cnt"}, 64'(rds), 64'(t.exp_rd));
        check({p, "_wdrd_cnt"}, 64'(wrs), 64'(t.exp_wr));
        check({p, "_rules"}, 64'(viol), 64'd0);
        check({p, "_stb_latency"}, 64'(stb_first - acc_cyc), 64'd1);
        check({p, "_bus_idle_at_done"}, 64'(bus_at_done), 64'd0);
        if (t.exp_err) check({p, "_stb_cycles"}, 64'(stb_cnt), 64'(TO));
        wb_ack_i = 1'b0;
        tick();
        check({p, "_done_pulse"}, 64'({done, err}), 64'd0);
    endtask

    initial begin
        int viol;
        int acks;
        int k;
        bit acc;

        tbl[0] = '{1'b1, 26'h000_0100, 4'hF, 4'd0,  3,   32'hDEAD_BEEF, 1'b0, 1,  0, 1};
        tbl[1] = '{1'b0, 26'h3FF_FFF0, 4'hF, 4'd7,  0,   32'h0,         1'b0, 8,  8, 0};
        tbl[2] = '{1'b1, 26'h000_0200, 4'h3, 4'd3,  1,   32'h1122_3344, 1'b0, 4,  0, 4};
        tbl[3] = '{1'b0, 26'h000_0040, 4'hC, 4'd0,  2,   32'h0,         1'b0, 1,  1, 0};
        tbl[4] = '{1'b1, 26'h100_0000, 4'hF, 4'd15, 0,   32'hA000_0001, 1'b0, 16, 0, 16};
        tbl[5] = '{1'b0, 26'h000_0080, 4'hF, 4'd2,  255, 32'h0,         1'b1, 0,  0, 0};
        tbl[6] = '{1'b1, 26'h000_0400, 4'hF, 4'd1,  255, 32'h55AA_55AA, 1'b1, 0,  0, 1};

        repeat (2) @(posedge wb_clk_i);
        #1;
        check_all_zero("reset");

        wb_rst_i  = 1'b0;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 26'h000_0100;
        viol      = 0;
        for (int i = 0; i < 10000; i++) begin
            #1;
            if (cmd_ready || wdata_rd) viol++;
            tick();
            if (wb_cyc_o || wb_stb_o) viol++;
        end
        check("init_wait_blocked", 64'(viol), 64'd0);

        sdr_init_done = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_txn(i);
        end
        check("no_spurious_in_traffic", 64'(spurious_ack), 64'd0);

        cmd_valid = 1'b0;
        wb_ack_i  = 1'b1;
        #1;
        check("spur_no_pull", 64'(wdata_rd), 64'd0);
        tick();
        wb_ack_i = 1'b0;
        check("spur_set", 64'(spurious_ack), 64'd1);
        check("spur_quiet", 64'({wb_cyc_o, wb_stb_o, rdata_vld, done, err}), 64'd0);
        repeat (3) tick();
        check("spur_sticky", 64'(spurious_ack), 64'd1);

        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 26'h000_0300;
        cmd_sel   = 4'hF;
        cmd_len   = 4'd3;
        wdata_i   = 32'hCAFE_0000;
        acks      = 0;
        k         = 0;
        while (acks < 2 && k < 50) begin
            #1;
            acc = cmd_valid && cmd_ready;
            if (wb_ack_i && wb_stb_o) acks++;
            tick();
            k++;
            if (acc) cmd_valid = 1'b0;
            wb_ack_i = wb_stb_o;
        end
        check("rst_burst_reached_beat3", 64'({acks, wb_stb_o}), 64'({32'd2, 1'b1}));
        wb_rst_i = 1'b1;
        #1;
        check("rst_no_pull", 64'(wdata_rd), 64'd0);
        tick();
        check_all_zero("rst_mid");
        wb_rst_i = 1'b0;
        wb_ack_i = 1'b0;
        #1;
        check("rst_to_init_wait", 64'({cmd_ready, done}), 64'd0);
        tick();
        #1;
        check("rst_then_idle", 64'({cmd_ready, done}), 64'({1'b1, 1'b0}));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
